mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single main-memory port between the icache (fetch-side miss refills, read-only) and the dcache (MEM-stage misses and write-throughs). It latches one request at a time, drives the memory handshake, and returns data with a one-cycle ack pulse to the winning cache. Ties are resolved round-robin so neither cache starves.

## Interface
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width for all ports
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  icache request, level, held until i_ack
- i_addr  in  ADDR_W  icache read address, stable while i_req
- i_data  out  DATA_W  read data, valid when i_ack
- i_ack  out  1  one-cycle completion pulse to icache
- d_req  in  1  dcache request, level, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  dcache address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, valid when d_ack on a read
- d_ack  out  1  one-cycle completion pulse to dcache
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, sampled on m_ack
- m_ack  in  1  memory completion, one-cycle pulse

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: only i_req -> BUSY_I; only d_req -> BUSY_D; both -> grant the side not equal to last_grant; none -> stay.
- On grant edge: latch addr/we/wdata into m_* registers, set m_req=1, update last_grant. icache grant forces m_we=0, m_wdata=0.
- BUSY_x: hold m_req and m_* stable; on m_ack -> RESP_x, m_req=0; read data captured from m_rdata into i_data (BUSY_I) or d_rdata (BUSY_D, reads only).
- RESP_x: x_ack=1 for exactly this cycle -> IDLE.
- Requesters drop req on the edge where they sample ack; arbiter never sees a stale req in the following IDLE.
- Once latched, a request is not cancellable; dropping req during BUSY/RESP has no effect, ack still issued (icache discards on fetch flush).
- A req dropped before it is granted produces no memory transaction.
- d_rdata unchanged on write completion; i_data/d_rdata hold last value between acks.
- m_ack outside BUSY_x is ignored.
- All outputs registered; no combinational path from any input to any output.

## Timing
- Reset: state=IDLE, last_grant=I (first tie goes to D), m_req=m_we=0, m_addr=m_wdata=0, i_ack=d_ack=0, i_data=d_rdata=0.
- rst mid-transaction: next cycle all of the above; in-flight request abandoned, no ack emitted; memory shares the same rst.
- Cycle 0 req seen in IDLE -> cycle 1 m_req=1; memory m_ack in cycle k≥1 -> cycle k+1 x_ack=1 with data -> cycle k+2 IDLE, new grant decision made in IDLE that cycle -> m_req in cycle k+3.
- Minimum turnaround (m_ack in cycle 1): ack in cycle 2, back-to-back m_req spacing 3 cycles.
- Continuous contention alternates D, I, D, I, ...

## Test plan
- Single icache read i_addr=0x100, memory acks 3 cycles after m_req with m_rdata=0x00000013 -> m_addr=0x100, m_we=0; i_ack high one cycle with i_data=0x00000013; d_ack stays 0.
- After reset, i_req(0x100) and d_req read(0x2000) same cycle -> m_addr sequence 0x2000 then 0x100; d_ack precedes i_ack.
- Both requesters re-raising req continuously for 4 transactions -> grant order D, I, D, I; no grant spacing below 3 cycles.
- dcache write d_addr=0x40, d_wdata=0xDEADBEEF with prior d_rdata=0x11111111 -> m_we=1, m_wdata=0xDEADBEEF; d_ack one cycle; d_rdata still 0x11111111.
- rst asserted while BUSY_D with m_req=1 -> next cycle m_req=0, all outputs at reset values, no d_ack; subsequent stray m_ack ignored, i_ack/d_ack stay 0.
- i_req raised while BUSY_D, dropped before d_ack -> no icache memory transaction, i_ack never asserted; stray m_ack in IDLE produces no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between icache and dcache
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t state, state_n;
    logic   last_d;
    logic   grant_i, grant_d;
    logic   done_i, done_d;

    // grant decision in IDLE (ties go to the side that lost last time) and next state
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        state_n = state;
        case (state)
            IDLE: begin
                grant_d = d_req && (!i_req || !last_d);
                grant_i = i_req && !grant_d;
                state_n = grant_d ? BUSY_D : (grant_i ? BUSY_I : IDLE);
            end
            BUSY_I:  state_n = m_ack ? RESP_I : BUSY_I;
            BUSY_D:  state_n = m_ack ? RESP_D : BUSY_D;
            default: state_n = IDLE;
        endcase
    end

    assign done_i = (state == BUSY_I) && m_ack;
    assign done_d = (state == BUSY_D) && m_ack;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // registered memory-side request and cache-side responses
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d  <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_data  <= '0;
            d_rdata <= '0;
        end else begin
            i_ack <= done_i;
            d_ack <= done_d;
            if (grant_i || grant_d) begin
                m_req   <= 1'b1;
                m_we    <= grant_d && d_we;
                m_addr  <= grant_d ? d_addr : i_addr;
                m_wdata <= grant_d ? d_wdata : '0;
                last_d  <= grant_d;
            end
            if (done_i || done_d) m_req <= 1'b0;
            if (done_i) i_data <= m_rdata;
            if (done_d && !m_we) d_rdata <= m_rdata;
        end
    end
endmodule
